// File: rtl/protocore_isa_pkg.sv
// ProtoCore ISA definitions shared by the instruction encoder and decoder.
package protocore_isa_pkg;

  localparam int unsigned WORD_W = 24;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned OP_LSB   = 20;
  localparam int unsigned RA_LSB   = 16;
  localparam int unsigned RB_LSB   = 12;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] OP_AND   = 4'h2;
  localparam logic [OP_W-1:0] OP_OR    = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h5;
  localparam logic [OP_W-1:0] OP_MOV   = 4'h6;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h7;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'h8;
  localparam logic [OP_W-1:0] OP_LDI   = 4'h9;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'hA;
  localparam logic [OP_W-1:0] OP_STORE = 4'hB;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'hC;
  localparam logic [OP_W-1:0] OP_BNE   = 4'hD;
  localparam logic [OP_W-1:0] OP_JMP   = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } instr_fields_t;

  typedef enum logic [2:0] {
    FMT_BIN, FMT_UNARY, FMT_IMM, FMT_MEM_ST, FMT_BRANCH, FMT_JUMP, FMT_HALT
  } instr_fmt_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_OVF} enc_state_e;

  function automatic instr_fmt_e op_fmt(input logic [OP_W-1:0] op);
    instr_fmt_e fmt;
    if (op <= OP_XOR)        fmt = FMT_BIN;
    else if (op <= OP_SHL)   fmt = FMT_UNARY;
    else if (op <= OP_LOAD)  fmt = FMT_IMM;
    else if (op == OP_STORE) fmt = FMT_MEM_ST;
    else if (op <= OP_BNE)   fmt = FMT_BRANCH;
    else if (op == OP_JMP)   fmt = FMT_JUMP;
    else                     fmt = FMT_HALT;
    return fmt;
  endfunction

endpackage

// File: rtl/instruction_pack.sv
// Packs assembled fields into the canonical 24-bit word, zeroing fields the format ignores.
module instruction_pack
  import protocore_isa_pkg::*;
(
  input  instr_fields_t     i_fields,
  output logic [WORD_W-1:0] o_word
);

  logic [REG_W-1:0]  w_ra;
  logic [REG_W-1:0]  w_rb;
  logic [REG_W-1:0]  w_rd;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    w_ra   = i_fields.ra;
    w_rb   = i_fields.rb;
    w_rd   = i_fields.rd;
    w_data = i_fields.data;
    case (op_fmt(i_fields.op))
      FMT_BIN:    w_data = '0;
      FMT_UNARY:  begin w_rb = '0; w_data = '0; end
      FMT_IMM:    w_rb = '0;
      FMT_MEM_ST: w_rd = '0;
      FMT_BRANCH: w_rd = '0;
      FMT_JUMP:   begin w_rb = '0; w_rd = '0; end
      FMT_HALT:   begin w_ra = '0; w_rb = '0; w_rd = '0; end
      default:    w_data = '0;
    endcase
  end

  always_comb begin
    o_word                     = '0;
    o_word[OP_LSB   +: OP_W]   = i_fields.op;
    o_word[RA_LSB   +: REG_W]  = w_ra;
    o_word[RB_LSB   +: REG_W]  = w_rb;
    o_word[RD_LSB   +: REG_W]  = w_rd;
    o_word[DATA_LSB +: DATA_W] = w_data;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: packs streamed fields into ProtoCore words and writes them to instruction memory.
module instruction_encoder
  import protocore_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [REG_W-1:0]    in_ra,
  input  logic [REG_W-1:0]    in_rb,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [DATA_W-1:0]   in_data,
  output logic                imem_we,
  input  logic                imem_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                core_hold,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  enc_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_we, w_we_nxt;
  logic [WORD_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_last, w_last_nxt;
  logic              r_halt, w_halt_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ovf, w_ovf_nxt;

  instr_fields_t     w_fields;
  logic [WORD_W-1:0] w_word;
  logic [CNT_W-1:0]  w_slot;
  logic              w_is_last;
  logic              w_accept;
  logic              w_commit;

  assign w_fields = '{op: in_op, ra: in_ra, rb: in_rb, rd: in_rd, data: in_data};

  instruction_pack u_pack (
    .i_fields (w_fields),
    .o_word   (w_word)
  );

  assign in_ready  = (r_state == S_LOAD) && !r_last && (!r_we || imem_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_commit  = r_we && imem_ready;
  // Slot the accepted word lands in; a write still outstanding occupies the current one.
  assign w_slot    = r_cnt + CNT_W'(r_we);
  assign w_is_last = (in_op == OP_HALT) || (w_slot == CNT_W'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    w_last_nxt  = r_last;
    w_halt_nxt  = r_halt;
    w_done_nxt  = r_done;
    w_ovf_nxt   = r_ovf;
    if (start) begin
      w_state_nxt = S_LOAD;
      w_ptr_nxt   = ADDR_W'(BASE_ADDR);
      w_cnt_nxt   = '0;
      w_we_nxt    = 1'b0;
      w_last_nxt  = 1'b0;
      w_halt_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else if (r_state == S_LOAD) begin
      if (w_commit) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_we_nxt  = 1'b0;
        if (r_last) begin
          // Final slot stays on the address bus so ptr never steps past the image.
          w_last_nxt  = 1'b0;
          w_state_nxt = r_halt ? S_DONE : S_OVF;
          w_done_nxt  = r_halt;
          w_ovf_nxt   = !r_halt;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      if (w_accept) begin
        w_we_nxt    = 1'b1;
        w_wdata_nxt = w_word;
        w_last_nxt  = w_is_last;
        w_halt_nxt  = (in_op == OP_HALT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= ADDR_W'(BASE_ADDR);
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
      r_last  <= w_last_nxt;
      r_halt  <= w_halt_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_ptr;
  assign imem_wdata = r_wdata;
  assign core_hold  = (r_state == S_LOAD);
  assign done       = r_done;
  assign overflow   = r_ovf;
  assign word_count = r_cnt;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a full-depth instance and a DEPTH=4 instance share stimulus.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        imem_ready = 1'b1;
  logic [3:0]  in_op = '0, in_ra = '0, in_rb = '0, in_rd = '0;
  logic [7:0]  in_data = '0;

  logic        in_ready, imem_we, core_hold, done, overflow;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic [8:0]  word_count;

  logic        s_in_ready, s_imem_we, s_core_hold, s_done, s_overflow;
  logic [7:0]  s_imem_addr;
  logic [23:0] s_imem_wdata;
  logic [8:0]  s_word_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_data(in_data),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done),
    .overflow(overflow), .word_count(word_count)
  );

  instruction_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_data(in_data),
    .imem_we(s_imem_we), .imem_ready(imem_ready), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .core_hold(s_core_hold), .done(s_done),
    .overflow(s_overflow), .word_count(s_word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic [7:0] data);
    in_op = op; in_ra = ra; in_rb = rb; in_rd = rd; in_data = data;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_reset_vals("rst0");
    rst = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic stream: ADD, NOT, HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_hold", 32'(core_hold), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd1);
    check("load_count0", 32'(word_count), 32'd0);
    imem_ready = 1'b1;
    in_valid = 1'b1;
    fields(4'h0, 4'h1, 4'h2, 4'h3, 8'h77);
    tick();
    check("add_we", 32'(imem_we), 32'd1);
    check("add_addr", 32'(imem_addr), 32'd0);
    check("add_wdata", 32'(imem_wdata), 32'h012300);
    fields(4'h5, 4'h4, 4'h9, 4'h5, 8'h33);
    tick();
    check("not_addr", 32'(imem_addr), 32'd1);
    check("not_wdata", 32'(imem_wdata), 32'h540500);
    check("not_count", 32'(word_count), 32'd1);
    fields(4'hF, 4'h3, 4'h4, 4'h5, 8'h2A);
    tick();
    in_valid = 1'b0;
    check("halt_addr", 32'(imem_addr), 32'd2);
    check("halt_wdata", 32'(imem_wdata), 32'hF0002A);
    check("halt_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("done_done", 32'(done), 32'd1);
    check("done_ovf", 32'(overflow), 32'd0);
    check("done_hold", 32'(core_hold), 32'd0);
    check("done_we", 32'(imem_we), 32'd0);
    check("done_count", 32'(word_count), 32'd3);
    in_valid = 1'b1;
    check("done_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // STORE packing and backpressure
    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_done_clr", 32'(done), 32'd0);
    imem_ready = 1'b0;
    in_valid = 1'b1;
    fields(4'hB, 4'h2, 4'h7, 4'h9, 8'h10);
    tick();
    fields(4'h1, 4'h1, 4'h2, 4'h3, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      check("bp_we", 32'(imem_we), 32'd1);
      check("bp_addr", 32'(imem_addr), 32'd0);
      check("bp_wdata", 32'(imem_wdata), 32'hB27010);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_count", 32'(word_count), 32'd0);
      if (i < 2) tick();
    end
    imem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_rel_addr", 32'(imem_addr), 32'd1);
    check("bp_rel_wdata", 32'(imem_wdata), 32'h112300);
    check("bp_rel_count", 32'(word_count), 32'd1);
    tick();
    check("bp_end_we", 32'(imem_we), 32'd0);
    check("bp_end_count", 32'(word_count), 32'd2);
    check("bp_end_hold", 32'(core_hold), 32'd1);

    // Overflow on the DEPTH=4 instance
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fields(4'h0, 4'h1, 4'h2, 4'(i), 8'h00);
      tick();
      check("ovf_addr", 32'(s_imem_addr), 32'(i));
      check("ovf_wdata", 32'(s_imem_wdata), 32'h012000 | 32'(i << 8));
    end
    check("ovf_last_ready", 32'(s_in_ready), 32'd0);
    tick();
    check("ovf_flag", 32'(s_overflow), 32'd1);
    check("ovf_done", 32'(s_done), 32'd0);
    check("ovf_count", 32'(s_word_count), 32'd4);
    check("ovf_hold", 32'(s_core_hold), 32'd0);
    check("ovf_in_ready", 32'(s_in_ready), 32'd0);
    tick();
    check("ovf_no_we", 32'(s_imem_we), 32'd0);
    in_valid = 1'b0;

    // Restart after the second accept drops the pending write
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    fields(4'h0, 4'h0, 4'h1, 4'h2, 8'h00);
    tick();
    fields(4'h2, 4'h3, 4'h4, 4'h5, 8'h00);
    tick();
    check("rs_pre_addr", 32'(imem_addr), 32'd1);
    check("rs_pre_count", 32'(word_count), 32'd1);
    start = 1'b1;
    imem_ready = 1'b0;
    fields(4'h3, 4'h9, 4'h9, 4'h9, 8'h00);
    tick();
    start = 1'b0;
    imem_ready = 1'b1;
    check("rs_we", 32'(imem_we), 32'd0);
    check("rs_addr", 32'(imem_addr), 32'd0);
    check("rs_count", 32'(word_count), 32'd0);
    check("rs_hold", 32'(core_hold), 32'd1);
    fields(4'h4, 4'h1, 4'h2, 4'h3, 8'h00);
    tick();
    in_valid = 1'b0;
    check("rs_new_addr", 32'(imem_addr), 32'd0);
    check("rs_new_wdata", 32'(imem_wdata), 32'h412300);
    tick();
    check("rs_new_count", 32'(word_count), 32'd1);

    // Asynchronous reset mid-stream, then reload
    imem_ready = 1'b0;
    in_valid = 1'b1;
    fields(4'h8, 4'h1, 4'h2, 4'h3, 8'h44);
    tick();
    check("ar_we", 32'(imem_we), 32'd1);
    check("ar_wdata", 32'(imem_wdata), 32'h810344);
    rst = 1'b0;
    #1;
    check_reset_vals("arst");
    in_valid = 1'b0;
    imem_ready = 1'b1;
    #2;
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    fields(4'hF, 4'h6, 4'h6, 4'h6, 8'h55);
    tick();
    in_valid = 1'b0;
    check("rl_addr", 32'(imem_addr), 32'd0);
    check("rl_wdata", 32'(imem_wdata), 32'hF00055);
    tick();
    check("rl_done", 32'(done), 32'd1);
    check("rl_count", 32'(word_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
